// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch stage. It generates sequential PCs, issues
//   valid/ready requests to instruction memory while enough credit remains,
//   and buffers the returned words with their PCs in a DEPTH-entry queue
//   that feeds Decode. A redirect reloads the PC, flushes the queue and
//   marks every still-outstanding response as stale so it is discarded on
//   arrival.
//   Build macro FETCH_ALIGN_CHECK_EN: a redirect to a target that is not
//   word aligned halts fetch and raises fetch_fault until an aligned
//   redirect arrives. Without the macro the low two target bits are ignored,
//   fetch_fault is tied low and fetch never halts.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [31:0]     ins_data,
    output logic [XLEN-1:0] ins_pc,
    output logic            fetch_fault
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(MAX_OUT + 1);

    localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [IW-1:0] MAX_OUT_W = IW'(MAX_OUT);

    // Fetch and response PCs
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;

    // Queue storage and bookkeeping
    logic [31:0]     r_q_data [DEPTH];
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    // Outstanding requests and how many of them are stale
    logic [IW-1:0]   r_inflight;
    logic [IW-1:0]   r_drop;

    logic [XLEN-1:0] w_target;
    logic            w_run;
    logic [CW:0]     w_occupancy;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;
    logic   r_fault;
    logic   w_misaligned;

    assign w_target     = redirect_pc;
    assign w_misaligned = |redirect_pc[1:0];
    assign w_run        = (r_state == ST_RUN);
    assign fetch_fault  = r_fault;

    // Halt on a misaligned redirect; only an aligned redirect resumes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_fault <= 1'b0;
        end else if (redirect) begin
            if (w_misaligned) begin
                r_state <= ST_HALT;
                r_fault <= 1'b1;
            end else begin
                r_state <= ST_RUN;
                r_fault <= 1'b0;
            end
        end
    end
`else
    assign w_target    = redirect_pc & ~XLEN'(3);
    assign w_run       = 1'b1;
    assign fetch_fault = 1'b0;
`endif

    // A slot is reserved for every outstanding request, so a response can
    // never land in a full queue. Valid is held low while reset is asserted.
    assign w_occupancy    = (CW + 1)'(r_count) + (CW + 1)'(r_inflight);
    assign imem_req_valid = rst & w_run & ~redirect
                          & (w_occupancy < DEPTH_W)
                          & (r_inflight < MAX_OUT_W);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_push  = imem_rsp_valid & ~redirect & w_run & (r_drop == '0);
    assign w_empty = (r_count == '0);
    assign w_pop   = ins_valid & ins_ready;

    assign ins_valid = ~w_empty & ~redirect & w_run;
    assign ins_data  = w_empty ? '0 : r_q_data[r_rd_ptr];
    assign ins_pc    = w_empty ? '0 : r_q_pc[r_rd_ptr];

    // Write a returned word and its PC into the tail slot.
    // NOTE: queue storage is deliberately not reset; r_count decides which
    // slots hold data, and the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= imem_rsp_data;
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    // PCs, queue pointers, occupancy and request/stale-response credits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            case ({w_req_fire, imem_rsp_valid})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: ;
            endcase

            if (redirect) begin
                // Everything still outstanding is stale, including a
                // response that arrives in this very cycle.
                r_pc     <= w_target;
                r_rsp_pc <= w_target;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_drop   <= r_inflight - IW'(imem_rsp_valid);
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - IW'(1);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(4);
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Credit accounting must never deliver a response into a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && (r_count == CNT_FULL)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
//   Directed bench for fetch_queue_unit with default parameters. A small
//   instruction-memory model answers accepted requests in order after a
//   programmable latency with word = addr ^ 32'h5A5A_0000; a monitor records
//   every word Decode accepts. Each task drives one scenario and compares
//   against hand-derived values. The fault scenario follows the
//   FETCH_ALIGN_CHECK_EN build macro.
module tb_fetch_queue_unit;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ins_valid;
    logic        ins_ready      = 1'b0;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        fetch_fault;

    int passed  = 0;
    int total   = 0;
    int mem_lat = 1;
    int cyc     = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } pop_t;

    req_t pend[$];
    req_t mem_new;
    pop_t popq[$];
    pop_t mon_new;

    fetch_queue_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: record accepted requests, forget them on reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend.delete();
            cyc = 0;
        end else begin
            cyc = cyc + 1;
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                mem_new.addr = imem_req_addr;
                mem_new.due  = cyc + mem_lat;
                pend.push_back(mem_new);
            end
        end
    end

    // Memory model: present the oldest response once its latency elapses.
    always @(negedge clk) begin
        if (rst && pend.size() > 0 && (cyc + 1 >= pend[0].due)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Decode-side monitor: log every accepted head entry.
    always @(posedge clk) begin
        if (rst && ins_valid === 1'b1 && ins_ready === 1'b1) begin
            mon_new.pc   = ins_pc;
            mon_new.data = ins_data;
            popq.push_back(mon_new);
        end
    end

    task automatic apply_reset(input int lat, input logic rdy);
        @(negedge clk);
        rst            = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        ins_ready      = rdy;
        mem_lat        = lat;
        @(negedge clk);
        popq.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); else passed++;
        total++; if (imem_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); else passed++;
        total++; if (ins_valid !== 1'b0) $display("FAIL reset_ins_valid: got %b expected 0", ins_valid); else passed++;
        total++; if (ins_data !== 32'h0) $display("FAIL reset_ins_data: got %h expected 00000000", ins_data); else passed++;
        total++; if (ins_pc !== 32'h0) $display("FAIL reset_ins_pc: got %h expected 00000000", ins_pc); else passed++;
        total++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fetch_fault); else passed++;
    endtask

    // Edge 1 requests 0, edge 2 stores it, edge 3 pops it: edges 3..12 pop 0..0x24.
    task automatic test_sequential();
        logic [31:0] exp_pc;
        apply_reset(1, 1'b1);
        repeat (12) @(negedge clk);
        #1;
        total++; if (popq.size() != 10) $display("FAIL seq_count: got %0d pops expected 10", popq.size()); else passed++;
        for (int i = 0; i < 10; i++) begin
            exp_pc = 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL seq_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL seq_pop%0d: got pc %h data %h expected pc %h data %h", i, popq[i].pc, popq[i].data, exp_pc, word_of(exp_pc));
            else passed++;
        end
    endtask

    // Decode stalled 10 cycles: queue fills with 0,4,8,C then requests stop.
    task automatic test_stall();
        logic [31:0] exp_pc;
        apply_reset(1, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); else passed++;
        total++; if (ins_valid !== 1'b1) $display("FAIL stall_ins_valid: got %b expected 1", ins_valid); else passed++;
        total++; if (ins_pc !== 32'h0 || ins_data !== word_of(32'h0)) $display("FAIL stall_head: got pc %h data %h expected pc 00000000 data %h", ins_pc, ins_data, word_of(32'h0)); else passed++;
        total++; if (popq.size() != 0) $display("FAIL stall_no_pop: got %0d pops expected 0", popq.size()); else passed++;
        ins_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        total++; if (popq.size() != 8) $display("FAIL stall_drain_count: got %0d pops expected 8", popq.size()); else passed++;
        for (int i = 0; i < 8; i++) begin
            exp_pc = 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL stall_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL stall_pop%0d: got pc %h data %h expected pc %h", i, popq[i].pc, popq[i].data, exp_pc);
            else passed++;
        end
    endtask

    // Latency 2: in cycle 3 requests 0 and 4 are outstanding and 0 returns.
    task automatic test_redirect_drop();
        logic [31:0] exp_pc;
        apply_reset(2, 1'b1);
        repeat (2) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL rdrop_req_gated: got %b expected 0", imem_req_valid); else passed++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++; if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) $display("FAIL rdrop_req_addr: got valid %b addr %h expected valid 1 addr 00000100", imem_req_valid, imem_req_addr); else passed++;
        repeat (10) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h100 + 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL rdrop_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL rdrop_pop%0d: got pc %h data %h expected pc %h data %h", i, popq[i].pc, popq[i].data, exp_pc, word_of(exp_pc));
            else passed++;
        end
    endtask

    // Cycle 4: queue holds 0,4; request 8 returns; request C would be accepted.
    task automatic test_redirect_collision();
        logic [31:0] exp_pc;
        apply_reset(1, 1'b0);
        repeat (3) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        ins_ready   = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL coll_req_gated: got %b expected 0", imem_req_valid); else passed++;
        total++; if (ins_valid !== 1'b0) $display("FAIL coll_ins_gated: got %b expected 0", ins_valid); else passed++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++; if (ins_valid !== 1'b0) $display("FAIL coll_flushed: got %b expected 0", ins_valid); else passed++;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) $display("FAIL coll_resume: got valid %b addr %h expected valid 1 addr 00000040", imem_req_valid, imem_req_addr); else passed++;
        repeat (6) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_pc = 32'h40 + 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL coll_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL coll_pop%0d: got pc %h data %h expected pc %h", i, popq[i].pc, popq[i].data, exp_pc);
            else passed++;
        end
    endtask

    // Two redirects in a row; the second sees one outstanding plus its response.
    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        apply_reset(2, 1'b1);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        redirect_pc = 32'h0000_0400;
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL b2b_req_gated: got %b expected 0", imem_req_valid); else passed++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++; if (imem_req_addr !== 32'h400) $display("FAIL b2b_req_addr: got %h expected 00000400", imem_req_addr); else passed++;
        repeat (8) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_pc = 32'h400 + 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL b2b_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL b2b_pop%0d: got pc %h data %h expected pc %h", i, popq[i].pc, popq[i].data, exp_pc);
            else passed++;
        end
    endtask

    // Fetch across the top of the address space: F8, FC, 0, 4.
    task automatic test_wrap();
        logic [31:0] exp_pc;
        apply_reset(1, 1'b1);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++; if (imem_req_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_addr0: got %h expected fffffff8", imem_req_addr); else passed++;
        @(negedge clk);
        #1;
        total++; if (imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr1: got %h expected fffffffc", imem_req_addr); else passed++;
        @(negedge clk);
        #1;
        total++; if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) $display("FAIL wrap_addr2: got valid %b addr %h expected valid 1 addr 00000000", imem_req_valid, imem_req_addr); else passed++;
        repeat (6) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL wrap_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL wrap_pop%0d: got pc %h data %h expected pc %h data %h", i, popq[i].pc, popq[i].data, exp_pc, word_of(exp_pc));
            else passed++;
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect halts fetch; an aligned one clears the fault.
    task automatic test_align();
        logic [31:0] exp_pc;
        apply_reset(1, 1'b1);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++; if (fetch_fault !== 1'b1) $display("FAIL align_fault_set: got %b expected 1", fetch_fault); else passed++;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL align_halt_req: got %b expected 0", imem_req_valid); else passed++;
        repeat (3) @(negedge clk);
        #1;
        total++; if (imem_req_valid !== 1'b0 || ins_valid !== 1'b0) $display("FAIL align_halt_hold: got req %b ins %b expected 0 0", imem_req_valid, ins_valid); else passed++;
        total++; if (popq.size() != 0) $display("FAIL align_halt_pops: got %0d expected 0", popq.size()); else passed++;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++; if (fetch_fault !== 1'b0) $display("FAIL align_fault_clr: got %b expected 0", fetch_fault); else passed++;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) $display("FAIL align_resume: got valid %b addr %h expected valid 1 addr 00000200", imem_req_valid, imem_req_addr); else passed++;
        repeat (6) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_pc = 32'h200 + 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL align_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL align_pop%0d: got pc %h expected %h", i, popq[i].pc, exp_pc);
            else passed++;
        end
    endtask
`else
    // Without the alignment check the low target bits are simply dropped.
    task automatic test_align();
        logic [31:0] exp_pc;
        apply_reset(1, 1'b1);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        #1;
        total++; if (fetch_fault !== 1'b0) $display("FAIL align_fault_tied: got %b expected 0", fetch_fault); else passed++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++; if (fetch_fault !== 1'b0) $display("FAIL align_fault_after: got %b expected 0", fetch_fault); else passed++;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) $display("FAIL align_forced: got valid %b addr %h expected valid 1 addr 00000100", imem_req_valid, imem_req_addr); else passed++;
        repeat (6) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_pc = 32'h100 + 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL align_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL align_pop%0d: got pc %h expected %h", i, popq[i].pc, exp_pc);
            else passed++;
        end
    endtask
`endif

    // Reset asserted mid-cycle while busy, then fetch restarts from RESET_PC.
    task automatic test_reset_midrun();
        logic [31:0] exp_pc;
        apply_reset(1, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        total++; if (ins_valid !== 1'b1) $display("FAIL mid_busy: got %b expected 1", ins_valid); else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0 || ins_valid !== 1'b0) $display("FAIL mid_valids: got req %b ins %b expected 0 0", imem_req_valid, ins_valid); else passed++;
        total++; if (imem_req_addr !== 32'h0 || ins_pc !== 32'h0 || ins_data !== 32'h0) $display("FAIL mid_values: got addr %h pc %h data %h expected all 0", imem_req_addr, ins_pc, ins_data); else passed++;
        @(negedge clk);
        popq.delete();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++; if (popq.size() != 3) $display("FAIL mid_count: got %0d pops expected 3", popq.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(4 * i);
            total++;
            if (popq.size() <= i) $display("FAIL mid_pop%0d: missing, got %0d pops", i, popq.size());
            else if (popq[i].pc !== exp_pc || popq[i].data !== word_of(exp_pc))
                $display("FAIL mid_pop%0d: got pc %h data %h expected pc %h", i, popq[i].pc, popq[i].data, exp_pc);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_redirect_collision();
        test_back_to_back();
        test_wrap();
        test_align();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
